// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: instruction fetch vs. data port onto one memory.
// Define MEM_ARBITER_ROUND_ROBIN_EN for round-robin instead of data-first priority.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_read,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_resp,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_byte_enable,
  output logic [31:0] d_rdata,
  output logic        d_resp,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SERVE_I = 2'd1;
  localparam logic [1:0] SERVE_D = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        wr_q, wr_d;
  logic        d_req;
  logic        grant_d;
  logic        grant_i;
  logic        serving;

  assign d_req = d_read | d_write;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  // last_d_q: 1 when the data port held the most recent grant
  logic last_d_q, last_d_d;

  always_comb begin
    grant_d  = d_req && (!i_read || !last_d_q);
    grant_i  = i_read && !grant_d;
    last_d_d = last_d_q;
    if (state_q == IDLE) begin
      if (grant_d)      last_d_d = 1'b1;
      else if (grant_i) last_d_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_d_q <= 1'b0;
    else        last_d_q <= last_d_d;
  end
`else
  assign grant_d = d_req;
  assign grant_i = i_read && !d_req;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    wr_d    = wr_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (grant_d) begin
          state_d = SERVE_D;
          addr_d  = d_addr;
          wr_d    = d_write;
          wdata_d = d_write ? d_wdata : 32'h0;
          be_d    = d_write ? d_byte_enable : 4'hF;
        end else if (grant_i) begin
          state_d = SERVE_I;
          addr_d  = i_addr;
          wr_d    = 1'b0;
          wdata_d = 32'h0;
          be_d    = 4'hF;
        end
      end
      (state_q == SERVE_I),
      (state_q == SERVE_D): begin
        if (mem_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      be_q    <= 4'hF;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      wr_q    <= wr_d;
    end
  end

  assign serving         = (state_q != IDLE);
  assign mem_read        = serving && !wr_q;
  assign mem_write       = serving && wr_q;
  assign mem_address     = addr_q;
  assign mem_wdata       = wdata_q;
  assign mem_byte_enable = be_q;
  assign i_resp          = (state_q == SERVE_I) && mem_resp;
  assign d_resp          = (state_q == SERVE_D) && mem_resp;
  assign i_rdata         = mem_rdata;
  assign d_rdata         = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: cycle vectors plus reset-abort
// and continuous-contention sequences.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_read;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_resp;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_byte_enable;
  logic [31:0] d_rdata;
  logic        d_resp;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_read          (i_read),
    .i_addr          (i_addr),
    .i_rdata         (i_rdata),
    .i_resp          (i_resp),
    .d_read          (d_read),
    .d_write         (d_write),
    .d_addr          (d_addr),
    .d_wdata         (d_wdata),
    .d_byte_enable   (d_byte_enable),
    .d_rdata         (d_rdata),
    .d_resp          (d_resp),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_byte_enable (mem_byte_enable),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp)
  );

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic        dw;
    logic [31:0] da;
    logic [31:0] dwd;
    logic [3:0]  dbe;
    logic        mr;
    logic [31:0] mrd;
    logic        e_mr;
    logic        e_mw;
    logic [31:0] e_addr;
    logic [31:0] e_wd;
    logic [3:0]  e_be;
    logic        e_ir;
    logic        e_dr;
  } vec_t;

  vec_t v[19];

  function automatic vec_t mk(
    input logic ir, input logic [31:0] ia,
    input logic dr, input logic dw,
    input logic [31:0] da, input logic [31:0] dwd,
    input logic [3:0] dbe,
    input logic mr, input logic [31:0] mrd,
    input logic emr, input logic emw,
    input logic [31:0] ea, input logic [31:0] ewd,
    input logic [3:0] ebe,
    input logic eir, input logic edr);
    vec_t r;
    r.ir = ir; r.ia = ia; r.dr = dr; r.dw = dw;
    r.da = da; r.dwd = dwd; r.dbe = dbe;
    r.mr = mr; r.mrd = mrd;
    r.e_mr = emr; r.e_mw = emw; r.e_addr = ea;
    r.e_wd = ewd; r.e_be = ebe;
    r.e_ir = eir; r.e_dr = edr;
    return r;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    i_read = 0; i_addr = 0;
    d_read = 0; d_write = 0; d_addr = 0;
    d_wdata = 0; d_byte_enable = 0;
    mem_resp = 0; mem_rdata = 0;
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();

    // ir ia dr dw da dwd dbe mr mrd | mr mw addr wd be ir dr
    v[0]  = mk(0,0,    0,0,0,0,0,          0,0,
               0,0,0,0,4'hF,0,0);
    v[1]  = mk(1,32'h60,0,0,0,0,0,         0,0,
               0,0,0,0,4'hF,0,0);
    v[2]  = mk(1,32'h60,0,0,0,0,0,         0,0,
               1,0,32'h60,0,4'hF,0,0);
    v[3]  = mk(1,32'h60,0,0,0,0,0,         0,0,
               1,0,32'h60,0,4'hF,0,0);
    v[4]  = mk(1,32'h60,0,0,0,0,0,         1,32'h00A00093,
               1,0,32'h60,0,4'hF,1,0);
    v[5]  = mk(0,0,    0,0,0,0,0,          0,0,
               0,0,32'h60,0,4'hF,0,0);
    v[6]  = mk(0,0,    0,0,0,0,0,          1,32'h1,
               0,0,32'h60,0,4'hF,0,0);
    v[7]  = mk(1,32'h80,0,1,32'h100,32'hDEADBEEF,4'h3, 0,0,
               0,0,32'h60,0,4'hF,0,0);
    v[8]  = mk(1,32'h80,0,1,32'h100,32'hDEADBEEF,4'h3, 0,0,
               0,1,32'h100,32'hDEADBEEF,4'h3,0,0);
    v[9]  = mk(1,32'h80,0,1,32'h100,32'hDEADBEEF,4'h3, 1,0,
               0,1,32'h100,32'hDEADBEEF,4'h3,0,1);
    v[10] = mk(1,32'h80,0,0,0,0,0,         0,0,
               0,0,32'h100,32'hDEADBEEF,4'h3,0,0);
    v[11] = mk(1,32'h80,0,0,0,0,0,         1,32'h5,
               1,0,32'h80,0,4'hF,1,0);
    v[12] = mk(0,0,    0,0,0,0,0,          0,0,
               0,0,32'h80,0,4'hF,0,0);
    v[13] = mk(0,0,    1,1,32'h40,32'h12345678,4'hC, 0,0,
               0,0,32'h80,0,4'hF,0,0);
    v[14] = mk(1,32'h90,0,0,0,0,0,         0,0,
               0,1,32'h40,32'h12345678,4'hC,0,0);
    v[15] = mk(0,0,    0,0,0,0,0,          1,0,
               0,1,32'h40,32'h12345678,4'hC,0,1);
    v[16] = mk(0,0,    1,0,32'h44,0,4'h0,  0,0,
               0,0,32'h40,32'h12345678,4'hC,0,0);
    v[17] = mk(0,0,    1,0,32'h44,0,4'h0,  1,32'h77,
               1,0,32'h44,0,4'hF,0,1);
    v[18] = mk(0,0,    0,0,0,0,0,          0,0,
               0,0,32'h44,0,4'hF,0,0);

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_be", mem_byte_enable, 4'hF);
    chk("rst_i_resp", i_resp, 0);
    chk("rst_d_resp", d_resp, 0);
    @(negedge clk);
    rst_n = 1;

    for (int k = 0; k < 19; k++) begin
      @(negedge clk);
      i_read = v[k].ir; i_addr = v[k].ia;
      d_read = v[k].dr; d_write = v[k].dw;
      d_addr = v[k].da; d_wdata = v[k].dwd;
      d_byte_enable = v[k].dbe;
      mem_resp = v[k].mr; mem_rdata = v[k].mrd;
      #1;
      chk($sformatf("v%0d_mem_read", k), mem_read, v[k].e_mr);
      chk($sformatf("v%0d_mem_write", k), mem_write, v[k].e_mw);
      chk($sformatf("v%0d_addr", k), mem_address, v[k].e_addr);
      chk($sformatf("v%0d_wdata", k), mem_wdata, v[k].e_wd);
      chk($sformatf("v%0d_be", k), mem_byte_enable, v[k].e_be);
      chk($sformatf("v%0d_i_resp", k), i_resp, v[k].e_ir);
      chk($sformatf("v%0d_d_resp", k), d_resp, v[k].e_dr);
      if (k == 4) chk("v4_i_rdata", i_rdata, 32'h00A00093);
    end

    // Reset during the second strobe cycle of a data write
    @(negedge clk);
    idle_inputs();
    d_write = 1; d_addr = 32'h300;
    d_wdata = 32'h55; d_byte_enable = 4'hF;
    #1;
    chk("ab_idle_mw", mem_write, 0);
    @(negedge clk); #1;
    chk("ab_strobe1_mw", mem_write, 1);
    @(negedge clk); #1;
    chk("ab_strobe2_mw", mem_write, 1);
    rst_n = 0;
    mem_resp = 1;
    #1;
    chk("ab_rst_mw", mem_write, 0);
    chk("ab_rst_d_resp", d_resp, 0);
    chk("ab_rst_addr", mem_address, 0);
    chk("ab_rst_wdata", mem_wdata, 0);
    chk("ab_rst_be", mem_byte_enable, 4'hF);
    d_write = 0;
    @(negedge clk);
    rst_n = 1;
    #1;
    chk("ab_late_d_resp", d_resp, 0);
    chk("ab_late_i_resp", i_resp, 0);
    chk("ab_late_mw", mem_write, 0);
    @(negedge clk);
    mem_resp = 0;
    #1;
    chk("ab_after_mw", mem_write, 0);
    chk("ab_after_mr", mem_read, 0);

    // Both requesters pending continuously, memory answers at once
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    i_read = 1; i_addr = 32'h1000;
    d_read = 1; d_addr = 32'h2000;
    mem_resp = 1; mem_rdata = 32'h13579BDF;
    for (int k = 0; k < 8; k++) begin
      logic exp_d;
      logic exp_i;
      if (k > 0) @(negedge clk);
      #1;
      exp_d = 0;
      exp_i = 0;
      if (k % 2 == 1) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        exp_d = ((k / 2) % 2 == 0);
        exp_i = !exp_d;
`else
        exp_d = 1;
`endif
      end
      chk($sformatf("rr%0d_d_resp", k), d_resp, exp_d);
      chk($sformatf("rr%0d_i_resp", k), i_resp, exp_i);
      chk($sformatf("rr%0d_addr", k), mem_address,
          (k % 2 == 1) ? (exp_d ? 32'h2000 : 32'h1000)
                       : mem_address);
      if (exp_d) chk($sformatf("rr%0d_d_rdata", k), d_rdata, 32'h13579BDF);
      if (exp_i) chk($sformatf("rr%0d_i_rdata", k), i_rdata, 32'h13579BDF);
    end
    @(negedge clk);
    idle_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
